// File: rtl/alu_seq_if.sv
// Operand/opcode request and result/status bundle for alu_seq.
`timescale 1ns/1ps
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       operation;
  logic             c_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             c_out;
  logic             zero;
  logic             overflow;

  // Requester side: drives operands, observes handshake and results
  modport master (
    output start, a, b, operation, c_in,
    input  busy, done, result, result_hi, c_out, zero, overflow
  );

  // ALU side: consumes operands, produces handshake and results
  modport slave (
    input  start, a, b, operation, c_in,
    output busy, done, result, result_hi, c_out, zero, overflow
  );
endinterface

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with start/busy/done handshake and a
// multi-cycle shift-add multiplier (opcode 1100) giving a 2*WIDTH product.
`timescale 1ns/1ps
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       OP_MUL = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t             state_r, state_nx_s;
  logic [2*WIDTH-1:0] acc_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [CW-1:0]      cnt_r;
  logic [WIDTH:0]     sum_s;
  logic               last_s;
  logic               mul_start_s;

  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_cout_s;
  logic               alu_ovf_s;
  logic [WIDTH:0]     wide_s;

  logic               busy_r, busy_nx_s;
  logic               done_r, done_nx_s;
  logic [WIDTH-1:0]   result_r, result_nx_s;
  logic [WIDTH-1:0]   result_hi_r, result_hi_nx_s;
  logic               c_out_r, c_out_nx_s;
  logic               zero_r, zero_nx_s;
  logic               overflow_r, overflow_nx_s;

  assign mul_start_s = bus.start && (bus.operation == OP_MUL);
  assign last_s      = (cnt_r == CW'(WIDTH - 1));

  // Single-cycle opcodes evaluated straight from the operands seen on the start edge
  always_comb begin
    alu_res_s  = ZERO_W;
    alu_cout_s = 1'b0;
    alu_ovf_s  = 1'b0;
    wide_s     = {(WIDTH+1){1'b0}};
    case (bus.operation)
      4'b0000: alu_res_s = bus.a & bus.b;
      4'b0001: alu_res_s = bus.a | bus.b;
      4'b0010: alu_res_s = ~(bus.a & bus.b);
      4'b0011: alu_res_s = ~(bus.a | bus.b);
      4'b0100: alu_res_s = bus.a ^ bus.b;
      4'b0101: alu_res_s = ~(bus.a ^ bus.b);
      4'b0110: alu_res_s = ~bus.a;
      4'b0111: alu_res_s = ~bus.b;
      4'b1000: begin
        alu_res_s  = ZERO_W - bus.a;
        alu_cout_s = (bus.a == ZERO_W);
      end
      4'b1001: begin
        alu_res_s  = ZERO_W - bus.b;
        alu_cout_s = (bus.b == ZERO_W);
      end
      4'b1010: begin
        wide_s     = {1'b0, bus.a} + {1'b0, bus.b} + {ZERO_W, bus.c_in};
        alu_res_s  = wide_s[WIDTH-1:0];
        alu_cout_s = wide_s[WIDTH];
        alu_ovf_s  = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                     (alu_res_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b1011: begin
        alu_res_s  = bus.a - bus.b;
        alu_cout_s = (bus.a < bus.b);
        alu_ovf_s  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                     (alu_res_s[WIDTH-1] != bus.a[WIDTH-1]);
      end
      4'b1101: begin
        alu_res_s  = bus.b - bus.a;
        alu_cout_s = (bus.b < bus.a);
        alu_ovf_s  = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                     (alu_res_s[WIDTH-1] != bus.b[WIDTH-1]);
      end
      4'b1110: begin
        wide_s     = {1'b0, bus.a} + {1'b0, ONE_W};
        alu_res_s  = wide_s[WIDTH-1:0];
        alu_cout_s = wide_s[WIDTH];
        alu_ovf_s  = !bus.a[WIDTH-1] && alu_res_s[WIDTH-1];
      end
      4'b1111: begin
        alu_res_s  = bus.a - ONE_W;
        alu_cout_s = (bus.a == ZERO_W);
        alu_ovf_s  = bus.a[WIDTH-1] && !alu_res_s[WIDTH-1];
      end
      default: begin
        alu_res_s  = ZERO_W;
        alu_cout_s = 1'b0;
        alu_ovf_s  = 1'b0;
      end
    endcase
  end

  // Partial sum for one shift-add step; keeps the carry as bit WIDTH
  always_comb begin
    if (acc_r[0]) begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
    end else begin
      sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]};
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (mul_start_s) begin
          state_nx_s = ST_MUL;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (last_s) begin
          state_nx_s = ST_FIN;
        end else begin
          state_nx_s = ST_MUL;
        end
      end
      ST_FIN:  state_nx_s = ST_IDLE;
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs; they hold unless updated
  always_comb begin
    busy_nx_s      = busy_r;
    done_nx_s      = 1'b0;
    result_nx_s    = result_r;
    result_hi_nx_s = result_hi_r;
    c_out_nx_s     = c_out_r;
    zero_nx_s      = zero_r;
    overflow_nx_s  = overflow_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.operation == OP_MUL) begin
            busy_nx_s = 1'b1;
          end else begin
            done_nx_s      = 1'b1;
            result_nx_s    = alu_res_s;
            result_hi_nx_s = ZERO_W;
            c_out_nx_s     = alu_cout_s;
            zero_nx_s      = (alu_res_s == ZERO_W);
            overflow_nx_s  = alu_ovf_s;
          end
        end else begin
          busy_nx_s = 1'b0;
        end
      end
      ST_MUL: begin
        if (last_s) begin
          busy_nx_s = 1'b0;
        end else begin
          busy_nx_s = 1'b1;
        end
      end
      ST_FIN: begin
        busy_nx_s      = 1'b0;
        done_nx_s      = 1'b1;
        result_nx_s    = acc_r[WIDTH-1:0];
        result_hi_nx_s = acc_r[2*WIDTH-1:WIDTH];
        c_out_nx_s     = (acc_r[2*WIDTH-1:WIDTH] != ZERO_W);
        zero_nx_s      = (acc_r == {(2*WIDTH){1'b0}});
        overflow_nx_s  = 1'b0;
      end
      default: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
      end
    endcase
  end

  // Output registers; reset clears everything so an aborted multiply leaves no trace
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      result_r    <= ZERO_W;
      result_hi_r <= ZERO_W;
      c_out_r     <= 1'b0;
      zero_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      busy_r      <= busy_nx_s;
      done_r      <= done_nx_s;
      result_r    <= result_nx_s;
      result_hi_r <= result_hi_nx_s;
      c_out_r     <= c_out_nx_s;
      zero_r      <= zero_nx_s;
      overflow_r  <= overflow_nx_s;
    end
  end

  // Multiplier datapath: multiplier in the low half, partial product shifts in from the top
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r   <= {(2*WIDTH){1'b0}};
      mcand_r <= ZERO_W;
      cnt_r   <= {CW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (mul_start_s) begin
            acc_r   <= {ZERO_W, bus.b};
            mcand_r <= bus.a;
            cnt_r   <= {CW{1'b0}};
          end
        end
        ST_MUL: begin
          acc_r <= {sum_s, acc_r[WIDTH-1:1]};
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.result_hi = result_hi_r;
  assign bus.c_out     = c_out_r;
  assign bus.zero      = zero_r;
  assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): vector table for 1-cycle ops,
// hand sequences for multiply timing, busy collision, back-to-back and reset abort.
`timescale 1ns/1ps
module tb_alu_seq;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  alu_seq_if #(.WIDTH(8)) bus ();

  alu_seq #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] res;
    logic       cout;
    logic       zero;
    logic       ovf;
  } vec_t;

  vec_t vecs [21];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic apply_vec(input vec_t v, input string nm);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.operation = v.op;
    bus.a         = v.a;
    bus.b         = v.b;
    bus.c_in      = v.cin;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({nm, " done"},      {31'd0, bus.done},     32'd1);
    chk({nm, " result"},    {24'd0, bus.result},   {24'd0, v.res});
    chk({nm, " result_hi"}, {24'd0, bus.result_hi}, 32'd0);
    chk({nm, " c_out"},     {31'd0, bus.c_out},    {31'd0, v.cout});
    chk({nm, " zero"},      {31'd0, bus.zero},     {31'd0, v.zero});
    chk({nm, " overflow"},  {31'd0, bus.overflow}, {31'd0, v.ovf});
  endtask

  task automatic run_mul(input string nm, input logic [7:0] ma, input logic [7:0] mb,
                         input bit collide, input logic [7:0] e_hi, input logic [7:0] e_lo,
                         input logic e_c, input logic e_z);
    int busy_cnt;
    int done_at;
    int done_cnt;
    logic [7:0] got_hi;
    logic [7:0] got_lo;
    logic got_c;
    logic got_z;
    logic got_v;
    got_hi = 8'hxx; got_lo = 8'hxx; got_c = 1'bx; got_z = 1'bx; got_v = 1'bx;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.operation = 4'b1100;
    bus.a         = ma;
    bus.b         = mb;
    bus.c_in      = 1'b0;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    busy_cnt  = bus.busy ? 1 : 0;
    done_cnt  = bus.done ? 1 : 0;
    done_at   = bus.done ? 0 : -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (done_at < 0) begin
          done_at = k;
          got_hi = bus.result_hi;
          got_lo = bus.result;
          got_c  = bus.c_out;
          got_z  = bus.zero;
          got_v  = bus.overflow;
        end
      end
      if (collide && k == 2) begin
        bus.start     = 1'b1;
        bus.operation = 4'b1010;
        bus.a         = 8'h11;
        bus.b         = 8'h22;
      end
      if (collide && k == 3) bus.start = 1'b0;
    end
    chk({nm, " busy cycles"}, busy_cnt, 32'd8);
    chk({nm, " done latency"}, done_at, 32'd9);
    chk({nm, " done count"}, done_cnt, 32'd1);
    chk({nm, " result_hi"}, {24'd0, got_hi}, {24'd0, e_hi});
    chk({nm, " result"},    {24'd0, got_lo}, {24'd0, e_lo});
    chk({nm, " c_out"},     {31'd0, got_c},  {31'd0, e_c});
    chk({nm, " zero"},      {31'd0, got_z},  {31'd0, e_z});
    chk({nm, " overflow"},  {31'd0, got_v},  32'd0);
  endtask

  initial begin
    int dcnt;
    n_vec  = 0;
    n_miss = 0;
    //          op       a      b      cin   res    cout  zero  ovf
    vecs[0]  = '{4'b1010, 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{4'b1010, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[2]  = '{4'b1010, 8'hFF, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'b1011, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{4'b1101, 8'h03, 8'h05, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{4'b1011, 8'h42, 8'h42, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{4'b0000, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'b0001, 8'hF0, 8'h3C, 1'b0, 8'hFC, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'b0010, 8'hF0, 8'h3C, 1'b0, 8'hCF, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'b0011, 8'hF0, 8'h3C, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{4'b0100, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'b0101, 8'hF0, 8'h3C, 1'b0, 8'h33, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'b0110, 8'hF0, 8'h3C, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{4'b0111, 8'hF0, 8'h3C, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{4'b1000, 8'h00, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[15] = '{4'b1001, 8'h00, 8'h05, 1'b0, 8'hFB, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{4'b1110, 8'h7F, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
    vecs[17] = '{4'b1110, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    vecs[18] = '{4'b1111, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{4'b1111, 8'h80, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[20] = '{4'b1011, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};

    bus.start     = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.operation = 4'b0000;
    bus.c_in      = 1'b0;
    rst           = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("reset busy",   {31'd0, bus.busy},      32'd0);
    chk("reset done",   {31'd0, bus.done},      32'd0);
    chk("reset result", {24'd0, bus.result},    32'd0);
    chk("reset hi",     {24'd0, bus.result_hi}, 32'd0);
    chk("reset flags",  {29'd0, bus.c_out, bus.zero, bus.overflow}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single-cycle opcode table
    for (int i = 0; i < 21; i++) begin
      apply_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Multiply timing and results
    run_mul("mul ff*ff", 8'hFF, 8'hFF, 1'b0, 8'hFE, 8'h01, 1'b1, 1'b0);
    run_mul("mul 00*ff", 8'h00, 8'hFF, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    run_mul("mul collide", 8'h0C, 8'h0A, 1'b1, 8'h00, 8'h78, 1'b0, 1'b0);

    // start held high: one done per cycle
    @(negedge clk);
    bus.start = 1'b1; bus.operation = 4'b1010; bus.a = 8'h01; bus.b = 8'h01; bus.c_in = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b first done",   {31'd0, bus.done},   32'd1);
    chk("b2b first result", {24'd0, bus.result}, 32'h02);
    @(negedge clk);
    bus.operation = 4'b0100; bus.a = 8'hFF; bus.b = 8'h0F;
    @(posedge clk);
    #1;
    chk("b2b second done",   {31'd0, bus.done},   32'd1);
    chk("b2b second result", {24'd0, bus.result}, 32'hF0);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b idle done",    {31'd0, bus.done},   32'd0);
    chk("b2b hold result",  {24'd0, bus.result}, 32'hF0);

    // Reset in the middle of a multiply
    @(negedge clk);
    bus.start = 1'b1; bus.operation = 4'b1100; bus.a = 8'hFF; bus.b = 8'hFF;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort busy before", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort busy",   {31'd0, bus.busy},      32'd0);
    chk("abort done",   {31'd0, bus.done},      32'd0);
    chk("abort result", {24'd0, bus.result},    32'd0);
    chk("abort hi",     {24'd0, bus.result_hi}, 32'd0);
    chk("abort flags",  {29'd0, bus.c_out, bus.zero, bus.overflow}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) dcnt++;
    end
    chk("abort no done", dcnt, 32'd0);
    apply_vec(vecs[0], "post-reset add");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Hard bound on run time in case the design stalls
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got stuck, want completion");
    $fatal(1);
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the lab 4-bit combinational ALU.
- Same 16-entry opcode map, generalised to WIDTH bits.
- Adds a start/busy/done handshake, registered outputs, status flags, and a multi-cycle shift-add multiplier producing a full 2*WIDTH product.
- Sits between the operand/opcode source (switches or a controller FSM) and the display/result logic.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request; sampled on a rising edge only when busy=0
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- operation  input  4  opcode; map below
- c_in  input  1  carry-in, used by opcode 1010 only
- busy  output  1  high while a multiply is in progress
- done  output  1  one-cycle pulse; result and flags are valid and newly updated
- result  output  WIDTH  low WIDTH bits of the outcome
- result_hi  output  WIDTH  high half of the product for 1100; 0 for all other ops
- c_out  output  1  carry/borrow, defined per opcode
- zero  output  1  high when result (and result_hi) are all 0
- overflow  output  1  signed two's-complement overflow for 1010/1011/1101/1110/1111; 0 otherwise

Behaviour:
- Reset is asynchronous and active-high. While rst=1: state=IDLE; busy, done, result, result_hi, c_out, zero and overflow are all 0.
- Operand capture: on the edge where start=1 and busy=0, latch a, b, operation and c_in internally. Input changes after that edge have no effect on the operation in flight.
- Opcode map:
  - 0000 AND, 0001 OR, 0010 NAND, 0011 NOR, 0100 XOR, 0101 XNOR, 0110 ~a, 0111 ~b: c_out=0.
  - 1000 -a (two's complement): c_out=1 iff a==0.
  - 1001 -b: c_out=1 iff b==0.
  - 1010 a+b+c_in: c_out is the carry out of the top bit.
  - 1011 a-b: c_out=1 iff a<b (unsigned borrow).
  - 1101 b-a: c_out=1 iff b<a.
  - 1110 a+1: c_out is the carry.
  - 1111 a-1: c_out=1 iff a==0.
  - 1100 a*b (unsigned): {result_hi,result} is the full 2*WIDTH product; c_out=1 iff result_hi!=0.
- FSM states: IDLE, MUL, FIN.
  - IDLE: if start and opcode!=1100, compute combinationally from the latched operands and register all outputs. done=1 on the following cycle, so latency is 1 cycle and state stays IDLE.
  - IDLE: if start and opcode==1100, clear the accumulator, set busy=1, set the iteration counter to 0, and go to MUL.
  - MUL: each cycle, if multiplier LSB=1, add the multiplicand to the upper half of the accumulator. Shift the accumulator right one bit, including the carry. Increment the counter. After WIDTH iterations go to FIN.
  - FIN: register {result_hi,result} and flags; busy=0; done=1; return to IDLE.
- Multiply latency: done asserts exactly WIDTH+1 cycles after the start edge. busy is high for WIDTH cycles.
- done pulses for exactly one cycle per accepted start.
- start while busy=1 is ignored: not queued, and it produces no done.
- start held high in IDLE back-to-back is accepted every cycle for 1-cycle ops, giving one done per cycle.
- result, result_hi and flags hold their last values until the next done.
- Width rules: all arithmetic is modulo 2^WIDTH except the multiply. Overflow is computed from operand and result sign bits:
  - add: same-sign operands, different-sign result.
  - sub: different-sign operands, result sign differs from the minuend.
  - inc/dec: wrap at the signed max/min.
- rst asserted mid-multiply: abort immediately, return to IDLE, clear all outputs. No done is issued for the aborted operation.

Test Plan:
- Reset: rst=1 mid-operation -> busy=0, done=0, result=0, result_hi=0, all flags 0, asynchronously with no clock edge needed. Release, then start 1010 a=0x05 b=0x03 c_in=0 -> one cycle later done=1, result=0x08, c_out=0, zero=0.
- Add carry/overflow: 1010 a=0x7F b=0x01 c_in=0 -> result=0x80, overflow=1, c_out=0. Then a=0xFF b=0x01 c_in=1 -> result=0x01, c_out=1, overflow=0.
- Subtract/borrow/zero:
  - 1011 a=0x03 b=0x05 -> result=0xFE, c_out=1.
  - 1101 same operands -> result=0x02, c_out=0.
  - 1011 a=b=0x42 -> result=0x00, zero=1.
- Multiply timing: 1100 a=0xFF b=0xFF -> busy high 8 cycles; done exactly 9 cycles after start; result_hi=0xFE, result=0x01, c_out=1. Also a=0x00 -> zero=1.
- Busy collision: start 1100 a=0x0C b=0x0A, then pulse start with 1010 during busy -> ignored; single done with result_hi=0x00, result=0x78.
- Logic/negation sweep: opcodes 0000-0111 with a=0xF0 b=0x3C -> 0x30, 0xFC, 0xCF, 0x03, 0xCC, 0x33, 0x0F, 0xC3, c_out=0. Opcode 1000 with a=0x00 -> result=0x00, c_out=1.
